load_exec_unit: RTL and testbench

- Responder on the issue side of the load buffer. Accepts issued LW instructions together with their instruction number and base-register value.
- Computes the effective address, performs a handshaked data-memory read, and returns the loaded word tagged with the instruction number to the ROB/CDB writeback path.
- Holds a small in-order queue so the load buffer can keep issuing while a memory access is outstanding.

---
 rtl/load_exec_unit_pkg.sv | 34 +++
 rtl/load_exec_fifo.sv | 70 +++++++
 rtl/load_exec_unit.sv | 168 ++++++++++++++++
 tb/tb_load_exec_unit.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_exec_unit_pkg.sv
//------------------------------------------------------------------------------
// load_exec_unit_pkg
// Shared types and constants for the load execution unit: LW opcode, FSM
// state encoding, queue entry layout and effective-address helper.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package load_exec_unit_pkg;

  localparam logic [5:0] OPC_LW = 6'b100011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WB   = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] instr_no;
    logic [4:0]  rt;
    logic [31:0] ea;
    logic        misaligned;
  } entry_t;

  // Base plus sign-extended 16-bit displacement, wrapping modulo 2^32.
  function automatic logic [31:0] calc_ea(input logic [31:0] base,
                                          input logic [15:0] off);
    return base + {{16{off[15]}}, off};
  endfunction

endpackage

`default_nettype wire

// File: rtl/load_exec_fifo.sv
//------------------------------------------------------------------------------
// load_exec_fifo
// Synchronous FIFO with asynchronous reset, head-of-queue read port and an
// occupancy count. Push when full and pop when empty are ignored.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module load_exec_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 70
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Storage array; contents are don't-care until written so no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally at DEPTH (power of 2); count tracks occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + CW'(1);
      end else if (do_pop && !do_push) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/load_exec_unit.sv
//------------------------------------------------------------------------------
// load_exec_unit
// Accepts issued LW instructions, computes the effective address, queues the
// load, performs a handshaked data-memory read and presents the tagged result
// on the writeback port. Misaligned addresses and memory timeouts complete
// with an error flag and zero data.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module load_exec_unit
  import load_exec_unit_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_valid,
  input  logic [31:0] ld_instr,
  input  logic [31:0] ld_instr_no,
  input  logic [31:0] ld_rs_val,
  output logic        ld_ready,
  output logic        ld_reject,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic [31:0] wb_instr_no,
  output logic [4:0]  wb_rt,
  output logic [31:0] wb_data,
  output logic        wb_err,
  input  logic        wb_ack,
  output logic [2:0]  pending
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(MEM_TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(MEM_TIMEOUT - 1);

  state_t        state;
  logic [TW-1:0] tmo_cnt;
  logic [31:0]   fl_instr_no;
  logic [4:0]    fl_rt;

  logic          is_lw;
  logic          accept;
  logic          push;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] count;
  logic [31:0]   ea;
  entry_t        new_entry;
  entry_t        head;

  assign is_lw  = (ld_instr[31:26] == OPC_LW);
  assign accept = ld_valid & ld_ready;
  assign push   = accept & is_lw;
  assign pop    = (state == ST_IDLE) & ~fifo_empty;

  assign ea                   = calc_ea(ld_rs_val, ld_instr[15:0]);
  assign new_entry.instr_no   = ld_instr_no;
  assign new_entry.rt         = ld_instr[20:16];
  assign new_entry.ea         = ea;
  assign new_entry.misaligned = (ea[1:0] != 2'b00);

  // No full bypass: readiness depends only on the registered count.
  assign ld_ready = ~fifo_full;
  assign pending  = 3'(count) + {2'b00, (state != ST_IDLE)};

  load_exec_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(entry_t))
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (new_entry),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count)
  );

  // One-cycle pulse after a non-LW instruction was offered and dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_reject <= 1'b0;
    end else begin
      ld_reject <= accept & ~is_lw;
    end
  end

  // Access sequencer: pop head, issue read (or fail fast), hold writeback.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      tmo_cnt     <= '0;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      wb_valid    <= 1'b0;
      wb_instr_no <= '0;
      wb_rt       <= '0;
      wb_data     <= '0;
      wb_err      <= 1'b0;
      fl_instr_no <= '0;
      fl_rt       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pop) begin
            fl_instr_no <= head.instr_no;
            fl_rt       <= head.rt;
            if (head.misaligned) begin
              state       <= ST_WB;
              wb_valid    <= 1'b1;
              wb_err      <= 1'b1;
              wb_data     <= '0;
              wb_instr_no <= head.instr_no;
              wb_rt       <= head.rt;
            end else begin
              state    <= ST_REQ;
              mem_req  <= 1'b1;
              mem_addr <= head.ea;
              tmo_cnt  <= '0;
            end
          end
        end
        ST_REQ: begin
          if (mem_ack) begin
            state       <= ST_WB;
            mem_req     <= 1'b0;
            wb_valid    <= 1'b1;
            wb_err      <= 1'b0;
            wb_data     <= mem_rdata;
            wb_instr_no <= fl_instr_no;
            wb_rt       <= fl_rt;
          end else if (tmo_cnt == TMO_LAST) begin
            state       <= ST_WB;
            mem_req     <= 1'b0;
            wb_valid    <= 1'b1;
            wb_err      <= 1'b1;
            wb_data     <= '0;
            wb_instr_no <= fl_instr_no;
            wb_rt       <= fl_rt;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        ST_WB: begin
          if (wb_ack) begin
            wb_valid <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_load_exec_unit.sv
//------------------------------------------------------------------------------
// tb_load_exec_unit
// Directed self-checking bench for load_exec_unit.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_load_exec_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_valid;
  logic [31:0] ld_instr;
  logic [31:0] ld_instr_no;
  logic [31:0] ld_rs_val;
  logic        ld_ready;
  logic        ld_reject;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        wb_valid;
  logic [31:0] wb_instr_no;
  logic [4:0]  wb_rt;
  logic [31:0] wb_data;
  logic        wb_err;
  logic        wb_ack;
  logic [2:0]  pending;

  logic        ack_en;
  int          vectors     = 0;
  int          miscompares = 0;

  localparam logic [5:0] LW = 6'b100011;
  localparam logic [5:0] SW = 6'b101011;

  // Memory responder: acks in the same cycle as the request when enabled,
  // returning the address XOR a fixed pattern as the data word.
  assign mem_ack   = ack_en & mem_req;
  assign mem_rdata = mem_addr ^ 32'hA5A5_0000;

  always #5 clk = ~clk;

  load_exec_unit #(
    .DEPTH       (4),
    .MEM_TIMEOUT (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ld_valid    (ld_valid),
    .ld_instr    (ld_instr),
    .ld_instr_no (ld_instr_no),
    .ld_rs_val   (ld_rs_val),
    .ld_ready    (ld_ready),
    .ld_reject   (ld_reject),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .wb_valid    (wb_valid),
    .wb_instr_no (wb_instr_no),
    .wb_rt       (wb_rt),
    .wb_data     (wb_data),
    .wb_err      (wb_err),
    .wb_ack      (wb_ack),
    .pending     (pending)
  );

  function automatic logic [31:0] mk_instr(input logic [5:0] opc, input logic [4:0] rt,
                                           input logic [15:0] off);
    return {opc, 5'd3, rt, off};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input logic [31:0] instr, input logic [31:0] no, input logic [31:0] rs);
    ld_valid    = 1'b1;
    ld_instr    = instr;
    ld_instr_no = no;
    ld_rs_val   = rs;
    tick();
    ld_valid    = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    vectors++;
    if (ld_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ld_ready got=%b exp=1", ld_ready); end
    vectors++;
    if (mem_req !== 1'b0 || wb_valid !== 1'b0 || ld_reject !== 1'b0) begin
      miscompares++; $display("FAIL reset_ctl got req=%b wbv=%b rej=%b exp=0", mem_req, wb_valid, ld_reject);
    end
    vectors++;
    if (pending !== 3'd0 || mem_addr !== 32'd0 || wb_data !== 32'd0) begin
      miscompares++; $display("FAIL reset_data got pend=%0d addr=%h data=%h exp=0", pending, mem_addr, wb_data);
    end
  endtask

  task automatic test_single_load();
    ack_en = 1'b1;
    wb_ack = 1'b0;
    enq(mk_instr(LW, 5'd5, 16'h0008), 32'd7, 32'h100);
    vectors++;
    if (mem_req !== 1'b0 || pending !== 3'd1) begin
      miscompares++; $display("FAIL single_n got req=%b pend=%0d exp req=0 pend=1", mem_req, pending);
    end
    tick();
    vectors++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h108) begin
      miscompares++; $display("FAIL single_req got req=%b addr=%h exp req=1 addr=00000108", mem_req, mem_addr);
    end
    tick();
    vectors++;
    if (wb_valid !== 1'b1 || wb_instr_no !== 32'd7 || wb_rt !== 5'd5 ||
        wb_data !== 32'hA5A5_0108 || wb_err !== 1'b0 || mem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL single_wb got v=%b no=%0d rt=%0d data=%h err=%b req=%b exp v=1 no=7 rt=5 data=a5a50108 err=0 req=0",
               wb_valid, wb_instr_no, wb_rt, wb_data, wb_err, mem_req);
    end
    wb_ack = 1'b1;
    tick();
    wb_ack = 1'b0;
    vectors++;
    if (wb_valid !== 1'b0 || pending !== 3'd0) begin
      miscompares++; $display("FAIL single_ack got v=%b pend=%0d exp v=0 pend=0", wb_valid, pending);
    end
  endtask

  task automatic test_neg_offset();
    logic [31:0] rs_tab   [2] = '{32'h10, 32'h0};
    logic [31:0] addr_tab [2] = '{32'h0000_000C, 32'hFFFF_FFFC};
    logic [31:0] data_tab [2] = '{32'hA5A5_000C, 32'h5A5A_FFFC};
    ack_en = 1'b1;
    wb_ack = 1'b1;
    for (int k = 0; k < 2; k++) begin
      enq(mk_instr(LW, 5'd9, 16'hFFFC), 32'd10 + k, rs_tab[k]);
      for (int n = 0; n < 8 && mem_req !== 1'b1; n++) tick();
      vectors++;
      if (mem_req !== 1'b1 || mem_addr !== addr_tab[k]) begin
        miscompares++; $display("FAIL negoff_addr[%0d] got req=%b addr=%h exp req=1 addr=%h", k, mem_req, mem_addr, addr_tab[k]);
      end
      for (int n = 0; n < 8 && wb_valid !== 1'b1; n++) tick();
      vectors++;
      if (wb_valid !== 1'b1 || wb_data !== data_tab[k] || wb_instr_no !== 32'd10 + k || wb_err !== 1'b0) begin
        miscompares++; $display("FAIL negoff_wb[%0d] got v=%b data=%h no=%0d err=%b exp v=1 data=%h no=%0d err=0",
                                k, wb_valid, wb_data, wb_instr_no, wb_err, data_tab[k], 10 + k);
      end
      tick();
    end
    wb_ack = 1'b0;
    tick();
  endtask

  task automatic test_misaligned_reject();
    logic saw_req;
    saw_req = 1'b0;
    ack_en  = 1'b1;
    wb_ack  = 1'b0;
    enq(mk_instr(LW, 5'd2, 16'h0000), 32'd30, 32'h101);
    for (int n = 0; n < 6 && wb_valid !== 1'b1; n++) begin
      if (mem_req === 1'b1) saw_req = 1'b1;
      tick();
    end
    vectors++;
    if (saw_req !== 1'b0 || mem_req !== 1'b0) begin
      miscompares++; $display("FAIL misal_noreq got saw_req=%b exp 0", saw_req);
    end
    vectors++;
    if (wb_valid !== 1'b1 || wb_err !== 1'b1 || wb_data !== 32'd0 || wb_instr_no !== 32'd30 || wb_rt !== 5'd2) begin
      miscompares++; $display("FAIL misal_wb got v=%b err=%b data=%h no=%0d rt=%0d exp v=1 err=1 data=0 no=30 rt=2",
                              wb_valid, wb_err, wb_data, wb_instr_no, wb_rt);
    end
    wb_ack = 1'b1;
    tick();
    wb_ack = 1'b0;
    ld_valid    = 1'b1;
    ld_instr    = mk_instr(SW, 5'd4, 16'h0010);
    ld_instr_no = 32'd31;
    ld_rs_val   = 32'h200;
    tick();
    ld_valid = 1'b0;
    vectors++;
    if (ld_reject !== 1'b1 || pending !== 3'd0) begin
      miscompares++; $display("FAIL reject_pulse got rej=%b pend=%0d exp rej=1 pend=0", ld_reject, pending);
    end
    tick();
    vectors++;
    if (ld_reject !== 1'b0 || mem_req !== 1'b0 || wb_valid !== 1'b0) begin
      miscompares++; $display("FAIL reject_end got rej=%b req=%b wbv=%b exp 0", ld_reject, mem_req, wb_valid);
    end
  endtask

  task automatic test_back_to_back();
    int k;
    ack_en = 1'b0;
    wb_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ld_valid    = 1'b1;
      ld_instr    = mk_instr(LW, 5'(i + 1), 16'(4 * i));
      ld_instr_no = 32'd20 + i;
      ld_rs_val   = 32'h400;
      tick();
    end
    ld_valid = 1'b0;
    vectors++;
    if (pending !== 3'd5 || ld_ready !== 1'b0) begin
      miscompares++; $display("FAIL b2b_full got pend=%0d rdy=%b exp pend=5 rdy=0", pending, ld_ready);
    end
    ack_en = 1'b1;
    wb_ack = 1'b1;
    k = 0;
    for (int n = 0; n < 60 && k < 5; n++) begin
      if (wb_valid === 1'b1) begin
        vectors++;
        if (wb_instr_no !== 32'd20 + k || wb_data !== ((32'h400 + 4 * k) ^ 32'hA5A5_0000)) begin
          miscompares++; $display("FAIL b2b_order[%0d] got no=%0d data=%h exp no=%0d data=%h",
                                  k, wb_instr_no, wb_data, 20 + k, (32'h400 + 4 * k) ^ 32'hA5A5_0000);
        end
        k++;
      end
      tick();
    end
    vectors++;
    if (k !== 5 || pending !== 3'd0) begin
      miscompares++; $display("FAIL b2b_drain got wbs=%0d pend=%0d exp wbs=5 pend=0", k, pending);
    end
    wb_ack = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    int cnt;
    ack_en = 1'b0;
    wb_ack = 1'b0;
    enq(mk_instr(LW, 5'd6, 16'h0000), 32'd50, 32'h200);
    enq(mk_instr(LW, 5'd7, 16'h0004), 32'd51, 32'h300);
    for (int n = 0; n < 4 && mem_req !== 1'b1; n++) tick();
    cnt = 0;
    while (mem_req === 1'b1 && cnt < 40) begin
      cnt++;
      tick();
    end
    vectors++;
    if (cnt !== 16) begin
      miscompares++; $display("FAIL tmo_len got %0d cycles exp 16", cnt);
    end
    vectors++;
    if (wb_valid !== 1'b1 || wb_err !== 1'b1 || wb_data !== 32'd0 || wb_instr_no !== 32'd50) begin
      miscompares++; $display("FAIL tmo_wb got v=%b err=%b data=%h no=%0d exp v=1 err=1 data=0 no=50",
                              wb_valid, wb_err, wb_data, wb_instr_no);
    end
    ack_en = 1'b1;
    wb_ack = 1'b1;
    tick();
    for (int n = 0; n < 10 && wb_valid !== 1'b1; n++) tick();
    vectors++;
    if (wb_valid !== 1'b1 || wb_err !== 1'b0 || wb_instr_no !== 32'd51 || wb_data !== 32'hA5A5_0304) begin
      miscompares++; $display("FAIL tmo_next got v=%b err=%b no=%0d data=%h exp v=1 err=0 no=51 data=a5a50304",
                              wb_valid, wb_err, wb_instr_no, wb_data);
    end
    tick();
    wb_ack = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_access();
    logic seen;
    ack_en = 1'b0;
    wb_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ld_valid    = 1'b1;
      ld_instr    = mk_instr(LW, 5'd8, 16'h0000);
      ld_instr_no = 32'd60 + i;
      ld_rs_val   = 32'h800;
      tick();
    end
    ld_valid = 1'b0;
    vectors++;
    if (mem_req !== 1'b1 || pending !== 3'd4) begin
      miscompares++; $display("FAIL rstmid_pre got req=%b pend=%0d exp req=1 pend=4", mem_req, pending);
    end
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if (mem_req !== 1'b0 || pending !== 3'd0 || ld_ready !== 1'b1) begin
      miscompares++; $display("FAIL rstmid_async got req=%b pend=%0d rdy=%b exp req=0 pend=0 rdy=1", mem_req, pending, ld_ready);
    end
    tick();
    rst    = 1'b0;
    ack_en = 1'b1;
    seen   = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (wb_valid === 1'b1 || mem_req === 1'b1) seen = 1'b1;
      tick();
    end
    vectors++;
    if (seen !== 1'b0 || pending !== 3'd0) begin
      miscompares++; $display("FAIL rstmid_after got activity=%b pend=%0d exp activity=0 pend=0", seen, pending);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst         = 1'b1;
    ld_valid    = 1'b0;
    ld_instr    = 32'd0;
    ld_instr_no = 32'd0;
    ld_rs_val   = 32'd0;
    wb_ack      = 1'b0;
    ack_en      = 1'b0;
    test_reset();
    test_single_load();
    test_neg_offset();
    test_misaligned_reject();
    test_back_to_back();
    test_timeout();
    test_reset_mid_access();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
